// File: rtl/clk_div_ctrl.sv
// Programmable clock-enable divider with a request/acknowledge controller for ratio changes.
// Define CLKDIV_LOCK_EN to add a `lock` input that rejects ratio-change requests.
module clk_div_ctrl #(
    parameter int CNT_W       = 4,
    parameter int SEL_W       = 2,
    parameter int DEFAULT_SEL = 0
) (
    input  logic             clk,
    input  logic             rst_n,
`ifdef CLKDIV_LOCK_EN
    input  logic             lock,
`endif
    input  logic             req_valid,
    input  logic [SEL_W-1:0] req_sel,
    output logic             req_ready,
    output logic             ack,
    output logic             err,
    output logic [SEL_W-1:0] cur_sel,
    output logic             div_out,
    output logic             div_tick
);

    localparam logic [SEL_W-1:0] DEF_SEL   = SEL_W'(DEFAULT_SEL);
    localparam logic [SEL_W:0]   SEL_LIMIT = (SEL_W+1)'(CNT_W);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;
    logic [SEL_W-1:0] pend_sel;
    logic [SEL_W-1:0] sel_eff;
    logic             switch_now;
    logic             div_next;
    logic             sel_bad;
    logic             locked;

`ifdef CLKDIV_LOCK_EN
    assign locked = lock;
`else
    assign locked = 1'b0;
`endif

    assign req_ready  = (state == IDLE);
    assign cnt_inc    = cnt + CNT_W'(1);
    assign sel_bad    = ({1'b0, req_sel} >= SEL_LIMIT);

    // The switch lands on the wrap edge, so the new ratio starts from a zero counter.
    assign switch_now = (state == WAIT) && (cnt == '1);
    assign sel_eff    = switch_now ? pend_sel : cur_sel;
    assign div_next   = cnt_inc[sel_eff];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            cur_sel  <= DEF_SEL;
            pend_sel <= DEF_SEL;
            ack      <= 1'b0;
            err      <= 1'b0;
            div_out  <= 1'b0;
            div_tick <= 1'b0;
        end else begin
            cnt      <= cnt_inc;
            div_out  <= div_next;
            div_tick <= div_next & ~div_out;
            ack      <= 1'b0;
            err      <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_valid) begin
                        if (locked || sel_bad) begin
                            err <= 1'b1;
                        end else if (req_sel == cur_sel) begin
                            ack   <= 1'b1;
                            state <= DONE;
                        end else begin
                            pend_sel <= req_sel;
                            state    <= WAIT;
                        end
                    end
                end
                WAIT: begin
                    if (switch_now) begin
                        cur_sel <= pend_sel;
                        ack     <= 1'b1;
                        state   <= DONE;
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_clk_div_ctrl.sv
// Directed bench for clk_div_ctrl with a response scoreboard and a cycle-indexed output model.
// Exercises the lock input too when CLKDIV_LOCK_EN is defined.
module tb_clk_div_ctrl;

    typedef struct {
        bit         isErr;
        int         dueCyc;
        logic [1:0] sel;
    } resp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic [1:0] req_sel = 2'd0;
    logic       req_ready, ack, err, div_out, div_tick;
    logic [1:0] cur_sel;
    logic       req_valid2 = 1'b0;
    logic [1:0] req_sel2 = 2'd0;
    logic       req_ready2, ack2, err2, div_out2, div_tick2;
    logic [1:0] cur_sel2;
`ifdef CLKDIV_LOCK_EN
    logic       lock = 1'b0;
    logic       lock2 = 1'b0;
`endif

    int         vectors = 0;
    int         miscompares = 0;
    int         cyc = 0;
    int         switchEdge = -1;
    int         busyFrom = -1;
    int         busyTo = -2;
    int         err2Due = -1;
    logic [1:0] msel = 2'd0;
    logic [1:0] newSel = 2'd0;
    logic       prevDiv = 1'b0;
    resp_t      sb[$];

    clk_div_ctrl #(.CNT_W(4), .SEL_W(2), .DEFAULT_SEL(0)) dut (
        .clk(clk), .rst_n(rst_n),
`ifdef CLKDIV_LOCK_EN
        .lock(lock),
`endif
        .req_valid(req_valid), .req_sel(req_sel), .req_ready(req_ready),
        .ack(ack), .err(err), .cur_sel(cur_sel), .div_out(div_out), .div_tick(div_tick)
    );

    clk_div_ctrl #(.CNT_W(3), .SEL_W(2), .DEFAULT_SEL(0)) dut3 (
        .clk(clk), .rst_n(rst_n),
`ifdef CLKDIV_LOCK_EN
        .lock(lock2),
`endif
        .req_valid(req_valid2), .req_sel(req_sel2), .req_ready(req_ready2),
        .ack(ack2), .err(err2), .cur_sel(cur_sel2), .div_out(div_out2), .div_tick(div_tick2)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("[TB] FAIL %s at cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic checkResetState();
        checkOutput("rst_div_out", 8'(div_out), 8'd0);
        checkOutput("rst_div_tick", 8'(div_tick), 8'd0);
        checkOutput("rst_ack", 8'(ack), 8'd0);
        checkOutput("rst_err", 8'(err), 8'd0);
        checkOutput("rst_ready", 8'(req_ready), 8'd1);
        checkOutput("rst_cur_sel", 8'(cur_sel), 8'd0);
        checkOutput("rst3_cur_sel", 8'(cur_sel2), 8'd0);
        checkOutput("rst3_ready", 8'(req_ready2), 8'd1);
    endtask

    // Asserts reset mid-cycle, holds it across two edges, then releases on a falling edge.
    task automatic doReset();
        rst_n = 1'b0;
        #1;
        checkResetState();
        repeat (2) begin
            @(posedge clk);
            #1;
            checkResetState();
        end
        @(negedge clk);
        rst_n      = 1'b1;
        cyc        = 0;
        msel       = 2'd0;
        prevDiv    = 1'b0;
        switchEdge = -1;
        busyFrom   = -1;
        busyTo     = -2;
        err2Due    = -1;
        sb.delete();
    endtask

    // After edge n the counter holds n mod 16, and div_out shows bit msel of it.
    task automatic stepCycle();
        logic [3:0] mcnt;
        logic       expDiv, expTick, expAck, expErr;
        resp_t      r;
        @(posedge clk);
        cyc++;
        if (cyc == switchEdge) msel = newSel;
        mcnt    = 4'(cyc % 16);
        expDiv  = mcnt[msel];
        expTick = expDiv & ~prevDiv;
        prevDiv = expDiv;
        expAck  = 1'b0;
        expErr  = 1'b0;
        #1;
        if (sb.size() > 0 && sb[0].dueCyc == cyc) begin
            r = sb.pop_front();
            if (r.isErr) expErr = 1'b1;
            else         expAck = 1'b1;
            checkOutput("resp_cur_sel", 8'(cur_sel), 8'(r.sel));
        end
        checkOutput("div_out", 8'(div_out), 8'(expDiv));
        checkOutput("div_tick", 8'(div_tick), 8'(expTick));
        checkOutput("cur_sel", 8'(cur_sel), 8'(msel));
        checkOutput("ack", 8'(ack), 8'(expAck));
        checkOutput("err", 8'(err), 8'(expErr));
        checkOutput("req_ready", 8'(req_ready), 8'(!(cyc >= busyFrom && cyc <= busyTo)));
        checkOutput("w3_err", 8'(err2), 8'(cyc == err2Due));
        checkOutput("w3_ack", 8'(ack2), 8'd0);
        checkOutput("w3_ready", 8'(req_ready2), 8'd1);
        checkOutput("w3_cur_sel", 8'(cur_sel2), 8'd0);
    endtask

    task automatic stepTo(input int target);
        while (cyc < target) stepCycle();
    endtask

    // Drives one request for a single cycle and queues the response the spec predicts.
    task automatic applyStimulus(input logic [1:0] sel, input bit expectErr);
        int acc;
        int sw;
        acc       = cyc + 1;
        req_valid = 1'b1;
        req_sel   = sel;
        if (expectErr) begin
            sb.push_back('{isErr: 1'b1, dueCyc: acc, sel: msel});
        end else if (sel == msel) begin
            sb.push_back('{isErr: 1'b0, dueCyc: acc, sel: msel});
            busyFrom = acc;
            busyTo   = acc;
        end else begin
            sw         = (acc / 16 + 1) * 16;
            switchEdge = sw;
            newSel     = sel;
            busyFrom   = acc;
            busyTo     = sw;
            sb.push_back('{isErr: 1'b0, dueCyc: sw, sel: sel});
        end
        stepCycle();
        req_valid = 1'b0;
    endtask

    initial begin
        doReset();
        stepTo(5);
        applyStimulus(2'd3, 1'b0);
        stepTo(31);
        applyStimulus(2'd2, 1'b0);
        stepTo(35);
        req_valid2 = 1'b1;
        req_sel2   = 2'd3;
        err2Due    = cyc + 1;
        stepCycle();
        req_valid2 = 1'b0;
        stepTo(50);
        applyStimulus(2'd2, 1'b0);
        stepTo(52);
        applyStimulus(2'd1, 1'b0);
        stepTo(70);
        applyStimulus(2'd1, 1'b0);
`ifdef CLKDIV_LOCK_EN
        stepTo(74);
        lock = 1'b1;
        applyStimulus(2'd2, 1'b1);
        lock = 1'b0;
`endif
        stepTo(80);
        applyStimulus(2'd2, 1'b0);
        stepTo(85);
        doReset();
        repeat (40) stepCycle();
        checkOutput("sb_empty", 8'(sb.size()), 8'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
